crc_serial: RTL and testbench
=============================

// Module: crc_serial
// PURPOSE
// - Bit-serial CRC generator, MSB-first, Galois (internal-XOR) LFSR.
// - Direct consumer of the XOR stage: XOR instances form the feedback tap
//   (in_bit ^ crc_reg[MSB]) and the polynomial fold into the shift register.
// - Accepts MSG_LEN message bits over a valid/ready handshake, then presents
//   the BIT_LEN-bit checksum until the sink takes it.
// PARAMETERS
// - BIT_LEN  8      CRC width in bits (>= 2)
// - POLY     8'h07  generator polynomial, implicit x^BIT_LEN term omitted
// - INIT     8'h00  crc_reg value loaded on start
// - MSG_LEN  8      message bits per frame (>= 1)
// PORTS
// - clk        in   1        rising-edge clock
// - rst_n      in   1        synchronous reset, active low
// - start      in   1        begin new frame; sampled only in IDLE
// - in_valid   in   1        in_bit is valid this cycle
// - in_bit     in   1        message bit, MSB of the message first
// - in_ready   out  1        block accepts a bit this cycle
// - busy       out  1        frame in progress (SHIFT or DONE)
// - out_valid  out  1        crc holds the final checksum
// - out_ready  in   1        sink accepts crc
// - crc        out  BIT_LEN  checksum register contents
// BEHAVIOUR
// - Single clock domain; all state updates on posedge clk.
// - Reset (rst_n=0 at an edge): state=IDLE, crc_reg=0, count=0;
//   in_ready=0, busy=0, out_valid=0, crc=0. Reset overrides every other input,
//   including mid-frame; the partial frame is discarded without output.
// - States: IDLE, SHIFT, DONE. Outputs are decoded from the registered state
//   only (Moore): in_ready=(SHIFT), busy=(SHIFT|DONE), out_valid=(DONE).
// - IDLE: start=1 -> crc_reg<=INIT, count<=0, next SHIFT. start=0 -> stay.
//   in_valid is ignored in IDLE.
// - SHIFT: a bit is accepted when in_valid & in_ready.
//   fb = in_bit ^ crc_reg[BIT_LEN-1];
//   crc_reg <= {crc_reg[BIT_LEN-2:0],1'b0} ^ (fb ? POLY : 0); count <= count+1.
//   When the accepted bit is bit number MSG_LEN-1 -> next DONE (the last
//   bit's update is included). in_valid=0 -> crc_reg and count hold.
//   start is ignored in SHIFT and DONE.
// - count width $clog2(MSG_LEN+1); never exceeds MSG_LEN-1 in SHIFT.
// - DONE: crc=crc_reg, stable while out_valid=1 & out_ready=0.
//   out_valid & out_ready -> next IDLE at that edge; crc_reg holds its value,
//   so crc keeps the last checksum in IDLE until the next start or reset.
// - Latency: first in_ready one cycle after start is sampled; out_valid one
//   cycle after the last bit is accepted. Minimum frame = MSG_LEN+2 cycles.
// - Back-to-back frames: start may be asserted in the cycle after the DONE
//   handshake (IDLE); start asserted during the handshake cycle is dropped.
// - crc output is the raw register: no reflection, no final XOR.
// TESTING (defaults unless stated)
// - rst_n=0 for 2 cycles mid-SHIFT -> in_ready=0, busy=0, out_valid=0, crc=0.
// - start, then bits of 8'h01 with in_valid held 1 -> out_valid after 8
//   accepts, crc=8'h07.
// - Frame 8'h80 -> crc=8'h89; frame 8'hFF -> crc=8'hF3.
// - MSG_LEN=72, ASCII "123456789", in_valid toggled pseudo-randomly
//   -> crc=8'hF4; count of accepted bits exactly 72.
// - DONE with out_ready=0 for 5 cycles, in_valid=1 and start=1 throughout
//   -> crc stable, no bits accepted; out_ready=1 -> IDLE next cycle.
// - INIT=8'hFF, frame 8'h00 -> crc=8'hF3; a second back-to-back frame
//   restarts from INIT, not from the previous checksum.

Source files
------------

// File: rtl/crc_serial.sv
// Bit-serial MSB-first CRC generator (Galois LFSR) with a valid/ready message input
// and a held checksum output that waits for the sink to take it.
module crc_serial #(
  parameter int                 BIT_LEN = 8,
  parameter logic [BIT_LEN-1:0] POLY    = 8'h07,
  parameter logic [BIT_LEN-1:0] INIT    = 8'h00,
  parameter int                 MSG_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               in_ready,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] crc
);

  localparam int CW = $clog2(MSG_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [BIT_LEN-1:0] crc_reg;
  logic [BIT_LEN-1:0] crc_next;
  logic [CW-1:0]      count_reg;
  logic               in_ready_reg;
  logic               busy_reg;
  logic               out_valid_reg;
  logic               fb;
  logic               accept;
  logic               last_bit;

  assign fb       = in_bit ^ crc_reg[BIT_LEN-1];
  assign accept   = in_valid & in_ready_reg;
  assign last_bit = (count_reg == LAST_IDX);

  // Shift left by one and fold the polynomial in wherever the feedback bit is set.
  generate
    for (genvar gi = 0; gi < BIT_LEN; gi++) begin : g_fold
      if (gi == 0) begin : g_lsb
        assign crc_next[gi] = fb & POLY[gi];
      end else begin : g_upper
        assign crc_next[gi] = crc_reg[gi-1] ^ (fb & POLY[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      crc_reg       <= '0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= SHIFT;
            crc_reg      <= INIT;
            count_reg    <= '0;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        SHIFT: begin
          if (accept) begin
            crc_reg   <= crc_next;
            count_reg <= count_reg + CW'(1);
            if (last_bit) begin
              state_reg     <= DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          // crc_reg is left untouched so the checksum stays visible in IDLE.
          if (out_ready) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b0;
          busy_reg      <= 1'b0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign busy      = busy_reg;
  assign out_valid = out_valid_reg;
  assign crc       = crc_reg;

endmodule

// File: tb/tb_crc_serial.sv
// Directed bench for crc_serial: three instances (default, 72-bit message, INIT=FF)
// checked against a polynomial long-division model and hand-computed checksums.
module tb_crc_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic [2:0] in_ready_v;
  logic [2:0] busy_v;
  logic [2:0] out_valid_v;
  logic [7:0] crc_v [3];

  int checks = 0;
  int errors = 0;
  int acc0 = 0;
  int acc1 = 0;

  always #5 clk = ~clk;

  crc_serial #(.BIT_LEN(8), .POLY(8'h07), .INIT(8'h00), .MSG_LEN(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_v[0]), .busy(busy_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .crc(crc_v[0]));

  crc_serial #(.BIT_LEN(8), .POLY(8'h07), .INIT(8'h00), .MSG_LEN(72)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_v[1]), .busy(busy_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .crc(crc_v[1]));

  crc_serial #(.BIT_LEN(8), .POLY(8'h07), .INIT(8'hFF), .MSG_LEN(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_v[2]), .busy(busy_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .crc(crc_v[2]));

  // Remainder of (message with INIT xored into its head, times x^8) modulo x^8+POLY.
  function automatic logic [7:0] crc_model(input logic [71:0] msg, input int len,
                                           input logic [7:0] init);
    bit       a [0:79];
    bit [8:0] gen;
    logic [7:0] r;
    gen = {1'b1, 8'h07};
    for (int i = 0; i < 80; i++) a[i] = 1'b0;
    for (int i = 0; i < len; i++) a[i] = msg[len-1-i];
    for (int i = 0; i < 8; i++) a[i] = a[i] ^ init[7-i];
    for (int i = 0; i < len; i++)
      if (a[i])
        for (int j = 0; j < 9; j++) a[i+j] = a[i+j] ^ gen[8-j];
    for (int j = 0; j < 8; j++) r[7-j] = a[len+j];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of instance 0, advanced on every rising edge.
  int          m_phase = 0;  // 0 idle, 1 collecting bits, 2 checksum held
  int          m_n = 0;
  logic [71:0] m_msg = '0;
  logic [7:0]  m_crc = '0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (in_valid && in_ready_v[0]) acc0++;
    if (in_valid && in_ready_v[1]) acc1++;
    if (!rst_n) begin
      m_phase = 0;
      m_crc   = 8'h00;
      m_live  = 1'b1;
    end else begin
      case (m_phase)
        0: if (start_v[0]) begin m_phase = 1; m_n = 0; m_msg = '0; end
        1: if (in_valid) begin
             m_msg = {m_msg[70:0], in_bit};
             m_n++;
             if (m_n == 8) begin
               m_phase = 2;
               m_crc   = crc_model(m_msg, 8, 8'h00);
             end
           end
        2: if (out_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_in_ready", 32'(in_ready_v[0]), 32'(m_phase == 1));
      check("cyc_busy", 32'(busy_v[0]), 32'(m_phase != 0));
      check("cyc_out_valid", 32'(out_valid_v[0]), 32'(m_phase == 2));
      if (m_phase != 1) check("cyc_crc", 32'(crc_v[0]), 32'(m_crc));
    end
  end

  task automatic send_frame(input int w, input logic [71:0] msg, input int len, input bit rnd,
                            input logic [7:0] exp_lit, input logic [7:0] init);
    int k = 0;
    int cyc = 0;
    bit acc;
    start_v[w] = 1'b1;
    tick();
    start_v[w] = 1'b0;
    while (k < len && cyc < 4000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_bit   = msg[len-1-k];
      acc      = in_valid && in_ready_v[w];
      tick();
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bits_accepted", 32'(k), 32'(len));
    check("out_valid_after_last", 32'(out_valid_v[w]), 32'd1);
    check("crc_literal", 32'(crc_v[w]), 32'(exp_lit));
    check("crc_vs_model", 32'(crc_v[w]), 32'(crc_model(msg, len, init)));
    $display("frame inst=%0d len=%0d msg=%0h crc=%0h", w, len, msg, crc_v[w]);
  endtask

  task automatic handshake(input int w);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_handshake", 32'(busy_v[w]), 32'd0);
  endtask

  initial begin
    int a0;
    rst_n = 1'b0; start_v = '0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    check("reset_in_ready", 32'(in_ready_v), 32'd0);
    check("reset_busy", 32'(busy_v), 32'd0);
    check("reset_out_valid", 32'(out_valid_v), 32'd0);
    check("reset_crc", 32'(crc_v[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    check("model_01", 32'(crc_model(72'h01, 8, 8'h00)), 32'h07);
    check("model_80", 32'(crc_model(72'h80, 8, 8'h00)), 32'h89);
    check("model_FF", 32'(crc_model(72'hFF, 8, 8'h00)), 32'hF3);
    check("model_00_initFF", 32'(crc_model(72'h00, 8, 8'hFF)), 32'hF3);

    send_frame(0, 72'h01, 8, 1'b0, 8'h07, 8'h00); handshake(0);
    send_frame(0, 72'h80, 8, 1'b0, 8'h89, 8'h00); handshake(0);
    send_frame(0, 72'hFF, 8, 1'b0, 8'hF3, 8'h00); handshake(0);

    // Reset in the middle of a frame.
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    check("midreset_in_ready", 32'(in_ready_v[0]), 32'd0);
    check("midreset_busy", 32'(busy_v[0]), 32'd0);
    check("midreset_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("midreset_crc", 32'(crc_v[0]), 32'd0);
    $display("midframe reset busy=%0d crc=%0h", busy_v[0], crc_v[0]);
    rst_n = 1'b1;
    tick();

    // Stall in DONE with noise on in_valid/start; start during handshake is dropped.
    send_frame(0, 72'h80, 8, 1'b0, 8'h89, 8'h00);
    a0 = acc0;
    in_valid = 1'b1; start_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_crc", 32'(crc_v[0]), 32'h89);
      check("stall_out_valid", 32'(out_valid_v[0]), 32'd1);
    end
    check("stall_no_accepts", 32'(acc0 - a0), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; start_v[0] = 1'b0; in_valid = 1'b0;
    check("stall_release_idle", 32'(busy_v[0]), 32'd0);
    tick();
    check("handshake_start_dropped", 32'(busy_v[0]), 32'd0);
    check("idle_crc_held", 32'(crc_v[0]), 32'h89);
    $display("stall test crc=%0h busy=%0d", crc_v[0], busy_v[0]);

    // 72-bit "123456789" with randomly gapped in_valid.
    acc1 = 0;
    send_frame(1, 72'h313233343536373839, 72, 1'b1, 8'hF4, 8'h00);
    check("accepted_72", 32'(acc1), 32'd72);
    handshake(1);

    // INIT=FF, back-to-back frames must each restart from INIT.
    send_frame(2, 72'h00, 8, 1'b0, 8'hF3, 8'hFF);
    handshake(2);
    send_frame(2, 72'h00, 8, 1'b0, 8'hF3, 8'hFF);
    handshake(2);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
